// File: rtl/w_writeback.sv
// Writeback stage: M/W pipeline register, sub-word load extension and GRF write-data select.
// Optional feature: define W_RETIRE_CNT_EN to build the retired-instruction counter.
module w_writeback #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        M_valid,
  input  logic [31:0] M_PC,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_WDSel,
  input  logic [2:0]  M_LoadType,
  input  logic [31:0] M_ALUOut,
  input  logic [31:0] M_DMRaw,
  input  logic [31:0] M_CP0Out,
  output logic        W_valid,
  output logic [31:0] W_PC,
  output logic [4:0]  W_A3,
  output logic [31:0] W_WD,
  output logic        W_we,
  output logic [31:0] W_retire_cnt
);

  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_LOAD = 2'd1;
  localparam logic [1:0] WD_PC8  = 2'd2;

  logic        valid_q,  valid_d;
  logic [31:0] pc_q,     pc_d;
  logic [4:0]  a3_q,     a3_d;
  logic [1:0]  wdsel_q,  wdsel_d;
  logic [2:0]  ldtype_q, ldtype_d;
  logic [1:0]  off_q,    off_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] dmraw_q,  dmraw_d;
  logic [31:0] cp0_q,    cp0_d;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    a3_d     = a3_q;
    wdsel_d  = wdsel_q;
    ldtype_d = ldtype_q;
    off_d    = off_q;
    aluout_d = aluout_q;
    dmraw_d  = dmraw_q;
    cp0_d    = cp0_q;
    if (flush) begin
      valid_d  = 1'b0;
      pc_d     = PC_RESET;
      a3_d     = 5'd0;
      wdsel_d  = 2'd0;
      ldtype_d = 3'd0;
      off_d    = 2'd0;
      aluout_d = 32'd0;
      dmraw_d  = 32'd0;
      cp0_d    = 32'd0;
    end else if (en) begin
      valid_d  = M_valid;
      pc_d     = M_PC;
      a3_d     = M_valid ? M_A3 : 5'd0;
      wdsel_d  = M_WDSel;
      ldtype_d = M_LoadType;
      off_d    = M_ALUOut[1:0];
      aluout_d = M_ALUOut;
      dmraw_d  = M_DMRaw;
      cp0_d    = M_CP0Out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= PC_RESET;
      a3_q     <= 5'd0;
      wdsel_q  <= 2'd0;
      ldtype_q <= 3'd0;
      off_q    <= 2'd0;
      aluout_q <= 32'd0;
      dmraw_q  <= 32'd0;
      cp0_q    <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      a3_q     <= a3_d;
      wdsel_q  <= wdsel_d;
      ldtype_q <= ldtype_d;
      off_q    <= off_d;
      aluout_q <= aluout_d;
      dmraw_q  <= dmraw_d;
      cp0_q    <= cp0_d;
    end
  end

  // offset[0] is deliberately ignored for halfwords; misalignment traps upstream
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_ext;

  always_comb begin
    ld_half = off_q[1] ? dmraw_q[31:16] : dmraw_q[15:0];
    case (off_q)
      2'd0:    ld_byte = dmraw_q[7:0];
      2'd1:    ld_byte = dmraw_q[15:8];
      2'd2:    ld_byte = dmraw_q[23:16];
      default: ld_byte = dmraw_q[31:24];
    endcase
    case (ldtype_q)
      LD_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  ld_ext = {16'd0, ld_half};
      LD_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  ld_ext = {24'd0, ld_byte};
      default: ld_ext = dmraw_q;
    endcase
  end

  always_comb begin
    case (wdsel_q)
      WD_ALU:  W_WD = aluout_q;
      WD_LOAD: W_WD = ld_ext;
      WD_PC8:  W_WD = pc_q + 32'd8;
      default: W_WD = cp0_q;
    endcase
  end

  assign W_valid = valid_q;
  assign W_PC    = pc_q;
  assign W_A3    = valid_q ? a3_q : 5'd0;
  assign W_we    = valid_q && (a3_q != 5'd0);

`ifdef W_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (en && !flush && M_valid) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= 32'd0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign W_retire_cnt = retire_cnt_q;
`else
  assign W_retire_cnt = 32'd0;
`endif

endmodule
